// File: rtl/psram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// psram_pkg: command codes, FSM states and defaults shared by the PSRAM pair
// Revision: 1.0
// ----------------------------------------------------------------------------
package psram_pkg;
  localparam logic [7:0] RSTEN     = 8'h66;
  localparam logic [7:0] RST       = 8'h99;
  localparam logic [7:0] ENTER_QPI = 8'h35;
  localparam logic [7:0] EXIT_QPI  = 8'hF5;
  localparam logic [7:0] QREAD     = 8'hEB;
  localparam logic [7:0] QWRITE    = 8'h02;
  localparam logic [7:0] QWRITE2   = 8'h38;

  localparam int DEFAULT_WAIT_CYC = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;
endpackage
`default_nettype wire

// File: rtl/psram_byte_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// psram_byte_array: byte RAM, synchronous write, asynchronous read + backdoor
// Revision: 1.0
// ----------------------------------------------------------------------------
module psram_byte_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  input  logic [ADDR_W-1:0] bd_addr_i,
  output logic [7:0]        bd_data_o
);
  logic [7:0] mem_q [2**ADDR_W];

  // No reset: contents survive rst_n like a real device array.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o   = mem_q[addr_i];
  assign bd_data_o = mem_q[bd_addr_i];
endmodule
`default_nettype wire

// File: rtl/psram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// psram_responder: QPI PSRAM device model (SPI bring-up, EBh read, 02h/38h write)
// Revision: 1.0
// ----------------------------------------------------------------------------
module psram_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = DEFAULT_WAIT_CYC,
  parameter bit INIT_QPI = 1'b0
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              mem_ce,
  input  logic [3:0]        sio_in,
  output logic [3:0]        sio_out,
  output logic [3:0]        sio_oe,
  output logic              qpi_mode,
  output logic              rd_active,
  output logic              cmd_err,
  input  logic [ADDR_W-1:0] bd_addr,
  output logic [7:0]        bd_data
);
  localparam int               CNT_W     = 8;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        hold_q, hold_d;
  logic              half_q, half_d;
  logic              is_rd_q, is_rd_d;
  logic              rst_en_q, rst_en_d;
  logic              qpi_q, qpi_d;
  logic [3:0]        sio_out_q, sio_out_d;
  logic [3:0]        sio_oe_q, sio_oe_d;
  logic              rd_active_q, rd_active_d;
  logic              cmd_err_q, cmd_err_d;

  logic [7:0] w_cmd_byte;
  logic       w_cmd_last;
  logic       w_go_addr;
  logic       w_we;
  logic [7:0] w_rdata;

  // The IDLE edge already shifts the first bit/nibble, so CMD sees cnt_q >= 1.
  assign w_cmd_byte = qpi_q ? {cmd_q[3:0], sio_in} : {cmd_q, sio_in[0]};
  assign w_cmd_last = (state_q == ST_CMD) && (cnt_q == (qpi_q ? CNT_W'(1) : CNT_W'(7)));
  assign w_go_addr  = qpi_q && ((w_cmd_byte == QREAD) || (w_cmd_byte == QWRITE) ||
                                (w_cmd_byte == QWRITE2));

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      half_q      <= 1'b0;
      is_rd_q     <= 1'b0;
      rst_en_q    <= 1'b0;
      qpi_q       <= INIT_QPI;
      sio_out_q   <= '0;
      sio_oe_q    <= '0;
      rd_active_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      half_q      <= half_d;
      is_rd_q     <= is_rd_d;
      rst_en_q    <= rst_en_d;
      qpi_q       <= qpi_d;
      sio_out_q   <= sio_out_d;
      sio_oe_q    <= sio_oe_d;
      rd_active_q <= rd_active_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mem_ce) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_CMD;
        ST_CMD:   if (w_cmd_last) state_d = w_go_addr ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (cnt_q == ADDR_LAST) state_d = is_rd_q ? ST_WAIT : ST_WDATA;
        ST_WAIT:  if (cnt_q == WAIT_LAST) state_d = ST_RDATA;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    half_d      = half_q;
    is_rd_d     = is_rd_q;
    rst_en_d    = rst_en_q;
    qpi_d       = qpi_q;
    sio_out_d   = sio_out_q;
    sio_oe_d    = sio_oe_q;
    rd_active_d = rd_active_q;
    cmd_err_d   = 1'b0;
    w_we        = 1'b0;
    if (mem_ce) begin
      cnt_d       = '0;
      half_d      = 1'b0;
      sio_out_d   = '0;
      sio_oe_d    = '0;
      rd_active_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_d = w_cmd_byte[6:0];
          cnt_d = CNT_W'(1);
        end
        ST_CMD: begin
          cmd_d = w_cmd_byte[6:0];
          cnt_d = cnt_q + 1'b1;
          if (w_cmd_last) begin
            cnt_d    = '0;
            half_d   = 1'b0;
            rst_en_d = 1'b0;
            is_rd_d  = (w_cmd_byte == QREAD);
            if (w_cmd_byte == RSTEN)                 rst_en_d  = 1'b1;
            else if (w_cmd_byte == RST && rst_en_q)  qpi_d     = 1'b0;
            else if (w_cmd_byte == ENTER_QPI && !qpi_q) qpi_d  = 1'b1;
            else if (w_cmd_byte == EXIT_QPI && qpi_q)   qpi_d  = 1'b0;
            else if (!w_go_addr)                     cmd_err_d = 1'b1;
          end
        end
        ST_ADDR: begin
          ptr_d = {ptr_q[ADDR_W-5:0], sio_in};
          cnt_d = (cnt_q == ADDR_LAST) ? '0 : cnt_q + 1'b1;
        end
        ST_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == WAIT_LAST) begin
            sio_out_d   = w_rdata[7:4];
            sio_oe_d    = 4'hF;
            rd_active_d = 1'b1;
            half_d      = 1'b0;
          end
        end
        ST_RDATA: begin
          if (!half_q) begin
            sio_out_d = w_rdata[3:0];
            ptr_d     = ptr_q + 1'b1;
            half_d    = 1'b1;
          end else begin
            sio_out_d = w_rdata[7:4];
            half_d    = 1'b0;
          end
        end
        ST_WDATA: begin
          if (!half_q) begin
            hold_d = sio_in;
            half_d = 1'b1;
          end else begin
            w_we   = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            half_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  psram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk       (mem_clk),
    .we_i      (w_we),
    .addr_i    (ptr_q),
    .wdata_i   ({hold_q, sio_in}),
    .rdata_o   (w_rdata),
    .bd_addr_i (bd_addr),
    .bd_data_o (bd_data)
  );

  assign sio_out   = sio_out_q;
  assign sio_oe    = sio_oe_q;
  assign qpi_mode  = qpi_q;
  assign rd_active = rd_active_q;
  assign cmd_err   = cmd_err_q;
endmodule
`default_nettype wire

// File: doc/psram_responder.md
Name: psram_responder

Overview:
- Synthesizable model of the QPI PSRAM device, i.e. the memory-side end of the mem_ce/mem_sio bus that the PSRAM controller drives.
- Decodes the SPI bring-up sequence (RSTEN, RST, enter-QPI), then serves QPI quad read (EBh) and quad write (02h/38h) from an internal byte array.
- Used as the on-chip loopback target for controller bring-up on Tang Nano 1k and as the bench's memory model.

Parameters:
- ADDR_W, 10, implemented address bits; the array holds 2^ADDR_W bytes and upper address bits are ignored.
- WAIT_CYC, 6, read dummy clocks between the last address nibble and the first data nibble.
- INIT_QPI, 0, qpi_mode value at reset (1 lets the bench skip bring-up).

Ports:
- mem_clk  in  1  bus clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_ce  in  1  chip enable, active low; sampled on mem_clk.
- sio_in  in  4  mem_sio as seen by the device; in SPI mode only sio_in[0] (SI) is used.
- sio_out  out  4  read data nibble, MSB nibble of each byte first.
- sio_oe  out  4  output enable per line; 4'hF only while returning read data.
- qpi_mode  out  1  1 = QPI command mode active.
- rd_active  out  1  high while read data is being driven.
- cmd_err  out  1  one-cycle pulse when an unsupported command completes.
- bd_addr  in  ADDR_W  backdoor read address, for bench checking.
- bd_data  out  8  combinational array[bd_addr].

Behaviour:
Reset:
- rst_n=0 gives state IDLE, sio_out=0, sio_oe=0, rd_active=0, cmd_err=0, qpi_mode=INIT_QPI, rst_en=0.
- Array contents are not cleared.

Chip enable:
- mem_ce=1 at any edge forces state IDLE, sio_oe=0, rd_active=0, and clears the counters. This is the only way a transaction ends.
- A write byte left with only one nibble when mem_ce rises is discarded.

States: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.

CMD state:
- Entered on the first edge with mem_ce=0.
- SPI mode: shifts in 8 bits from sio_in[0], MSB first, one per edge.
- QPI mode: shifts in 2 nibbles, high nibble first.
- On completion:
  - 66h: rst_en<=1, then IGNORE.
  - 99h with rst_en=1: qpi_mode<=0, rst_en<=0, then IGNORE.
  - 35h in SPI mode: qpi_mode<=1, then IGNORE.
  - F5h in QPI mode: qpi_mode<=0, then IGNORE.
  - EBh or 02h/38h in QPI mode: go to ADDR.
  - Anything else: cmd_err pulse, then IGNORE.
- Every completed command other than 66h clears rst_en.

ADDR state:
- 6 nibbles, MSB first, forming 24 bits; the low ADDR_W bits become the pointer.
- After the 6th nibble: read goes to WAIT, write goes to WDATA.

WAIT state:
- Counts WAIT_CYC edges; sio_oe stays 0.
- On the WAIT_CYC-th edge, registers sio_out=array[ptr][7:4], sio_oe=4'hF, rd_active=1, then goes to RDATA.
- Timing: command nibbles on edges 1–2, address on edges 3–8, first data driven from edge 8+WAIT_CYC.

RDATA state:
- Each edge alternately drives the low nibble, then the high nibble of array[ptr+1], with ptr incrementing after each low nibble.
- Continues until mem_ce rises.

WDATA state:
- Each pair of nibbles (high first) is written to array[ptr], then ptr increments.

Pointer and modes:
- ptr wraps modulo 2^ADDR_W for both read and write bursts.
- In SPI mode, EBh/02h are unsupported and produce cmd_err.
- The responder never drives the bus in SPI mode (no status read).

Decomposition:
- Shared package psram_pkg holds:
  - command constants RSTEN=66h, RST=99h, ENTER_QPI=35h, EXIT_QPI=F5h, QREAD=EBh, QWRITE=02h, QWRITE2=38h;
  - the state enum;
  - the default WAIT_CYC.
- The PSRAM controller should import the same constants.
- One natural sub-module, psram_byte_array: single-port synchronous-write byte RAM with asynchronous read plus a backdoor read port.

Test Plan:
- SPI: send 66h then 99h then 35h, with mem_ce high between commands -> qpi_mode 0,0,1; cmd_err never asserted.
- QPI write 02h, addr 000010h, data A5h,3Ch, then QPI read EBh at 000010h -> after 6 dummy clocks sio_out = A,5,3,C with sio_oe=F; bd_data at 10h reads A5h.
- Wrap (ADDR_W=10): write 11h,22h at 0003FFh -> bd_data[3FFh]=11h and bd_data[000h]=22h.
- mem_ce raised after 3 write nibbles (77h then 8) -> byte 77h stored, next byte unchanged; the following read at that address returns 77h.
- SPI 99h without a preceding 66h while qpi_mode=1 via INIT_QPI -> qpi_mode stays 1; QPI command 12h -> one cmd_err pulse and the bus stays undriven.
- rst_n pulsed low during RDATA -> sio_oe=0 and rd_active=0 immediately (asynchronous); array data preserved, confirmed by re-reading.
